// File: rtl/keypad_scanner.sv
// ----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 matrix keypad. One column strobe is driven low per slot, the
// active-low rows are sampled at the end of each slot, and the four column
// samples form a 16-bit frame snapshot. Once per frame the completed snapshot
// goes to a debounce FSM. The FSM accepts a single key after DEBOUNCE identical
// frames and confirms its release after DEBOUNCE empty frames. Each accepted
// code is shifted into a four-digit hex register for the display driver.
//
// Parameters
//   SCAN_DIV  clock cycles per column slot (>= 4)
//   DEBOUNCE  identical frames needed to accept a press or a release (1..15)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   row[3:0]   keypad rows, active low, asynchronous to clk
//   col[3:0]   column strobes, active low, exactly one low at a time
//   key_valid  one-cycle pulse when a key is accepted
//   key_code   code (4*row + col) of the last accepted key
//   key_held   high from accept until the release is confirmed
//   hexs       last four accepted codes, newest in [3:0]
// ----------------------------------------------------------------------------
module keypad_scanner #(
   parameter int SCAN_DIV = 131072,
   parameter int DEBOUNCE = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic        key_held,
   output logic [15:0] hexs
);

   localparam int            CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] SLOT_ONE  = CW'(1);
   localparam logic [3:0]    CNT_TGT   = 4'(DEBOUNCE);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_DEBOUNCE = 2'd1,
      S_PRESSED  = 2'd2,
      S_RELEASE  = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [3:0]    r_row_s1;
   logic [3:0]    r_row_s2;
   logic [CW-1:0] r_slot_cnt;
   logic [3:0]    r_col;
   logic [15:0]   r_snap;
   logic [15:0]   r_frame;       // completed snapshot handed to the FSM
   logic          r_frame_tick;  // one cycle after each frame end
   state_t        r_state;
   logic [3:0]    r_cnt;
   logic [3:0]    r_cand;
   logic          r_key_valid;
   logic [3:0]    r_key_code;
   logic          r_key_held;
   logic [15:0]   r_hexs;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic          w_slot_end;
   logic          w_frame_end;
   logic [1:0]    w_col_idx;
   logic [15:0]   w_snap_next;
   logic          w_none;
   logic          w_single;
   logic [3:0]    w_bit;
   logic [3:0]    w_code;

   assign w_slot_end  = (r_slot_cnt == SLOT_LAST);
   assign w_frame_end = w_slot_end && (w_col_idx == 2'd3);

   // Column index is the position of the single low strobe.
   always_comb begin
      // NOTE: every variable assigned in a combinational block gets a default
      // first, so no path leaves it unassigned and no latch is inferred.
      w_col_idx = 2'd0;
      case (r_col)
         4'b1101: w_col_idx = 2'd1;
         4'b1011: w_col_idx = 2'd2;
         4'b0111: w_col_idx = 2'd3;
         default: w_col_idx = 2'd0;
      endcase
   end

   // Snapshot with the current column's inverted rows merged in. At frame end
   // this is the complete frame, including the column-3 sample taken now.
   always_comb begin
      w_snap_next = r_snap;
      w_snap_next[{w_col_idx, 2'b00} +: 4] = ~r_row_s2;
   end

   // Frame classification. A power-of-two test finds exactly-one-bit-set.
   assign w_none   = (r_frame == 16'd0);
   assign w_single = !w_none && ((r_frame & (r_frame - 16'd1)) == 16'd0);

   // Snapshot bit 4c+r maps to key code 4r+c, i.e. the two index fields swap.
   always_comb begin
      w_bit  = 4'd0;
      w_code = 4'd0;
      for (int b = 0; b < 16; b++) begin
         if (r_frame[b]) begin
            w_bit  = 4'(b);
            w_code = {w_bit[1:0], w_bit[3:2]};
         end
      end
   end

   // ------------------------------------------------------------------------
   // Row synchronizer (two flops, rows are asynchronous to clk)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: sequential state is written with non-blocking assignments so
         // every flop samples the pre-edge value of its neighbours.
         r_row_s1 <= 4'd0;
         r_row_s2 <= 4'd0;
      end else begin
         r_row_s1 <= row;
         r_row_s2 <= r_row_s1;
      end
   end

   // ------------------------------------------------------------------------
   // Slot counter, column rotation and frame snapshot
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_slot_cnt   <= '0;
         r_col        <= 4'b1110;
         r_snap       <= 16'd0;
         r_frame      <= 16'd0;
         r_frame_tick <= 1'b0;
      end else begin
         r_frame_tick <= 1'b0;
         if (w_slot_end) begin
            r_slot_cnt <= '0;
            r_col      <= {r_col[2:0], r_col[3]};
            r_snap     <= w_snap_next;
            if (w_frame_end) begin
               r_frame      <= w_snap_next;
               r_frame_tick <= 1'b1;
            end
         end else begin
            r_slot_cnt <= r_slot_cnt + SLOT_ONE;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Debounce FSM with registered outputs. It acts on the cycle after frame
   // end, so all outputs change on the first edge after the frame-end edge.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_cand      <= 4'd0;
         r_key_valid <= 1'b0;
         r_key_code  <= 4'd0;
         r_key_held  <= 1'b0;
         r_hexs      <= 16'd0;
      end else begin
         r_key_valid <= 1'b0;
         if (r_frame_tick) begin
            case (r_state)
               S_IDLE: begin
                  if (w_single) begin
                     r_cand <= w_code;
                     if (DEBOUNCE == 1) begin
                        r_key_valid <= 1'b1;
                        r_key_code  <= w_code;
                        r_hexs      <= {r_hexs[11:0], w_code};
                        r_key_held  <= 1'b1;
                        r_cnt       <= 4'd0;
                        r_state     <= S_PRESSED;
                     end else begin
                        r_cnt   <= 4'd1;
                        r_state <= S_DEBOUNCE;
                     end
                  end
               end

               S_DEBOUNCE: begin
                  if (w_single) begin
                     if (w_code == r_cand) begin
                        if ((r_cnt + 4'd1) == CNT_TGT) begin
                           r_key_valid <= 1'b1;
                           r_key_code  <= r_cand;
                           r_hexs      <= {r_hexs[11:0], r_cand};
                           r_key_held  <= 1'b1;
                           r_cnt       <= 4'd0;
                           r_state     <= S_PRESSED;
                        end else begin
                           r_cnt <= r_cnt + 4'd1;
                        end
                     end else begin
                        // A different single key restarts the count.
                        r_cand <= w_code;
                        r_cnt  <= 4'd1;
                     end
                  end else begin
                     r_cnt   <= 4'd0;
                     r_state <= S_IDLE;
                  end
               end

               S_PRESSED: begin
                  // Any key activity keeps the press alive; no auto-repeat.
                  if (w_none) begin
                     if (DEBOUNCE == 1) begin
                        r_key_held <= 1'b0;
                        r_cnt      <= 4'd0;
                        r_state    <= S_IDLE;
                     end else begin
                        r_cnt   <= 4'd1;
                        r_state <= S_RELEASE;
                     end
                  end
               end

               S_RELEASE: begin
                  if (w_none) begin
                     if ((r_cnt + 4'd1) == CNT_TGT) begin
                        r_key_held <= 1'b0;
                        r_cnt      <= 4'd0;
                        r_state    <= S_IDLE;
                     end else begin
                        r_cnt <= r_cnt + 4'd1;
                     end
                  end else begin
                     r_cnt   <= 4'd0;
                     r_state <= S_PRESSED;
                  end
               end

               default: begin
                  r_cnt   <= 4'd0;
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign col       = r_col;
   assign key_valid = r_key_valid;
   assign key_code  = r_key_code;
   assign key_held  = r_key_held;
   assign hexs      = r_hexs;

endmodule

// File: tb/tb_keypad_scanner.sv
// ----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Bench for keypad_scanner with SCAN_DIV = 4 and DEBOUNCE = 2 (16-cycle
// frames). A keypad model pulls row r low while key 4r+c is held and col[c]
// is low. Keys only change just after a frame end, so each frame sees one
// fixed key set. A per-frame reference model predicts accept and release
// events and queues them with their expected cycle. A monitor pops the queue
// whenever the DUT pulses key_valid or drops key_held.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_keypad_scanner;

   localparam int SCAN_DIV = 4;
   localparam int DEBOUNCE = 2;
   localparam int FRAME    = 4 * SCAN_DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  row;
   logic [3:0]  col;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_held;
   logic [15:0] hexs;

   logic [15:0] keys = 16'd0;   // bit 4r+c set = key (r,c) held
   int          n;              // rising edges since reset release
   int          vectors     = 0;
   int          miscompares = 0;

   typedef struct {
      int          cyc;
      bit          is_accept;
      logic [3:0]  code;
      logic [15:0] hexs;
   } ev_t;

   ev_t exp_q[$];

   // Reference model state
   bit          m_held;
   int          m_run_code;
   int          m_run_len;
   int          m_empty_run;
   logic [15:0] m_hexs;

   keypad_scanner #(
      .SCAN_DIV(SCAN_DIV),
      .DEBOUNCE(DEBOUNCE)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .row      (row),
      .col      (col),
      .key_valid(key_valid),
      .key_code (key_code),
      .key_held (key_held),
      .hexs     (hexs)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst) begin
      if (!rst) n <= 0;
      else      n <= n + 1;
   end

   // Keypad matrix: a held key connects its row to its column strobe.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[4*r + c] && !col[c]) row[r] = 1'b0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, n);
      end
   endtask

   task automatic model_reset();
      m_held      = 1'b0;
      m_run_code  = 0;
      m_run_len   = 0;
      m_empty_run = 0;
      m_hexs      = 16'd0;
      exp_q.delete();
   endtask

   // Called at the start of a frame with that frame's key set. Predicts what
   // the scanner concludes at the end of the frame and when it shows it.
   task automatic model_frame(input logic [15:0] k);
      int  pc;
      int  code;
      int  cyc;
      ev_t ev;
      pc   = $countones(k);
      code = 0;
      for (int i = 0; i < 16; i++) if (k[i]) code = i;
      cyc = (n / FRAME + 1) * FRAME + 1;
      if (!m_held) begin
         if (pc == 1) begin
            m_run_len  = (m_run_len > 0 && code == m_run_code) ? m_run_len + 1 : 1;
            m_run_code = code;
            if (m_run_len >= DEBOUNCE) begin
               m_held       = 1'b1;
               m_run_len    = 0;
               m_empty_run  = 0;
               m_hexs       = {m_hexs[11:0], 4'(code)};
               ev.cyc       = cyc;
               ev.is_accept = 1'b1;
               ev.code      = 4'(code);
               ev.hexs      = m_hexs;
               exp_q.push_back(ev);
            end
         end else begin
            m_run_len = 0;
         end
      end else begin
         if (pc == 0) begin
            m_empty_run++;
            if (m_empty_run >= DEBOUNCE) begin
               m_held       = 1'b0;
               ev.cyc       = cyc;
               ev.is_accept = 1'b0;
               ev.code      = 4'd0;
               ev.hexs      = m_hexs;
               exp_q.push_back(ev);
            end
         end else begin
            m_empty_run = 0;
         end
      end
   endtask

   // Must be entered on a falling edge right after a frame end.
   task automatic apply(input logic [15:0] k, input int frames);
      for (int f = 0; f < frames; f++) begin
         keys = k;
         model_frame(k);
         repeat (FRAME) @(negedge clk);
      end
   endtask

   // Monitor: column rotation every cycle, plus event scoreboard.
   initial begin : monitor
      logic       prev_held;
      logic [3:0] exp_col;
      ev_t        ev;
      prev_held = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_held = 1'b0;
         end else begin
            exp_col = ~(4'b0001 << ((n / SCAN_DIV) % 4));
            check("col", col, exp_col);
            if (key_valid || (prev_held && !key_held)) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_event: key_valid=%0b key_held=%0b, expected no event (cycle %0d)",
                           key_valid, key_held, n);
               end else begin
                  ev = exp_q.pop_front();
                  check("event_is_accept", key_valid, ev.is_accept);
                  check("event_cycle", n, ev.cyc);
                  if (ev.is_accept) begin
                     check("key_code", key_code, ev.code);
                     check("hexs", hexs, ev.hexs);
                     check("key_held_on_accept", key_held, 1);
                  end
               end
            end
            prev_held = key_held;
         end
      end
   end

   initial begin
      model_reset();

      // 1. Reset, then idle scanning for 10 frames.
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_col", col, 4'b1110);
      check("rst_key_valid", key_valid, 0);
      check("rst_key_held", key_held, 0);
      check("rst_hexs", hexs, 16'h0000);
      rst = 1'b1;
      apply(16'h0000, 10);
      check("idle_hexs", hexs, 16'h0000);
      check("idle_key_code", key_code, 0);
      check("idle_key_held", key_held, 0);

      // 2. Single press of key r=2,c=1 (code 9) for 6 frames.
      apply(16'h0001 << 9, 6);
      apply(16'h0000, 3);
      check("single_key_code", key_code, 4'd9);
      check("single_hexs", hexs, 16'h0009);
      check("single_released", key_held, 0);

      // 3. Five-digit sequence.
      for (int d = 1; d <= 5; d++) begin
         apply(16'h0001 << d, 3);
         apply(16'h0000, 3);
         if (d == 4) check("seq_hexs_4", hexs, 16'h1234);
      end
      check("seq_hexs_5", hexs, 16'h2345);

      // 4. Bounce rejection, then a candidate change mid-debounce.
      for (int i = 0; i < 5; i++) begin
         apply(16'h0001, 1);
         apply(16'h0000, 1);
      end
      check("bounce_hexs", hexs, 16'h2345);
      apply(16'h0001 << 3, 1);
      apply(16'h0001 << 7, 2);
      apply(16'h0000, 3);
      check("cand_change_code", key_code, 4'd7);
      check("cand_change_hexs", hexs, 16'h3457);

      // 5. Two keys together, then a second key added while one is held.
      apply(16'h0021, 4);
      apply(16'h0000, 2);
      check("multi_hexs", hexs, 16'h3457);
      apply(16'h0001 << 6, 3);
      apply(16'h0440, 20);
      apply(16'h0000, 3);
      check("hold_key_code", key_code, 4'd6);
      check("hold_hexs", hexs, 16'h4576);

      // 6. Reset while a key is held, with hexs = 0x00AB.
      #2 rst = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      apply(16'h0001 << 10, 3);
      apply(16'h0000, 3);
      apply(16'h0001 << 11, 4);
      check("pre_reset_hexs", hexs, 16'h00AB);
      check("pre_reset_held", key_held, 1);
      #2 rst = 1'b0;
      #1;
      check("midrst_hexs", hexs, 16'h0000);
      check("midrst_key_held", key_held, 0);
      check("midrst_key_code", key_code, 0);
      check("midrst_key_valid", key_valid, 0);
      check("midrst_col", col, 4'b1110);
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      apply(16'h0001 << 11, 3);
      check("reaccept_hexs", hexs, 16'h000B);
      check("reaccept_code", key_code, 4'd11);
      apply(16'h0000, 3);

      check("events_outstanding", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
